// File: rtl/wb_master_bridge_if.sv
// Core-side request/response and Wishbone bus signals of wb_master_bridge.
// The master modport is the bridge's view; the slave modport is the environment's view.
interface wb_master_bridge_if;
  logic        req_i;
  logic        req_we_i;
  logic [31:0] req_adr_i;
  logic [31:0] req_dat_i;
  logic [3:0]  req_sel_i;
  logic        req_ready_o;
  logic        resp_valid_o;
  logic [31:0] resp_dat_o;
  logic        resp_err_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        wb_stall_i;

  modport master (
    input  req_i, req_we_i, req_adr_i, req_dat_i, req_sel_i,
    output req_ready_o, resp_valid_o, resp_dat_o, resp_err_o,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i, wb_err_i, wb_stall_i
  );

  modport slave (
    output req_i, req_we_i, req_adr_i, req_dat_i, req_sel_i,
    input  req_ready_o, resp_valid_o, resp_dat_o, resp_err_o,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_dat_i, wb_ack_i, wb_err_i, wb_stall_i
  );
endinterface

// File: rtl/wb_master_bridge.sv
// Wishbone B4 pipelined initiator: one single-beat transfer outstanding at a time.
// Define WB_MASTER_TIMEOUT_EN to abort hung cycles after TIMEOUT_CYCLES cycles.
module wb_master_bridge #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  wb_master_bridge_if.master  io_bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]  r_state;
  logic        r_cyc;
  logic        r_stb;
  logic        r_we;
  logic [31:0] r_adr;
  logic [31:0] r_dat;
  logic [3:0]  r_sel;
  logic        r_resp_valid;
  logic [31:0] r_resp_dat;
  logic        r_resp_err;

  logic        w_term;
  logic        w_timeout;
  logic        w_done;
  logic [31:0] w_rd_dat;

  // Ack/err only count once the address phase is accepted (not stalled) or in WAIT.
  assign w_term = ((r_state == S_REQ && !io_bus.wb_stall_i) || r_state == S_WAIT)
                  && (io_bus.wb_ack_i || io_bus.wb_err_i);

  assign w_rd_dat = (!io_bus.wb_err_i && !r_we) ? io_bus.wb_dat_i : 32'd0;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_cnt;
  logic        w_busy;

  assign w_busy = (r_state == S_REQ) || (r_state == S_WAIT);

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      r_cnt <= 16'd0;
    end else if (r_state == S_IDLE) begin
      r_cnt <= 16'd0;
    end else if (w_busy) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign w_timeout = w_busy && (r_cnt == TO_LAST) && !w_term;
`else
  // Without the watchdog the parameter has no effect; an out-of-range value simply never fires.
  assign w_timeout = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

  assign w_done = w_term || w_timeout;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      r_state      <= S_IDLE;
      r_cyc        <= 1'b0;
      r_stb        <= 1'b0;
      r_we         <= 1'b0;
      r_adr        <= 32'd0;
      r_dat        <= 32'd0;
      r_sel        <= 4'd0;
      r_resp_valid <= 1'b0;
      r_resp_dat   <= 32'd0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (io_bus.req_i) begin
            r_we    <= io_bus.req_we_i;
            r_adr   <= io_bus.req_adr_i;
            r_dat   <= io_bus.req_dat_i;
            r_sel   <= io_bus.req_sel_i;
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_state <= S_REQ;
          end
        end
        S_REQ, S_WAIT: begin
          if (w_done) begin
            r_state      <= S_IDLE;
            r_cyc        <= 1'b0;
            r_stb        <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_err   <= w_term ? io_bus.wb_err_i : 1'b1;
            r_resp_dat   <= w_term ? w_rd_dat : 32'd0;
          end else if (r_state == S_REQ && !io_bus.wb_stall_i) begin
            r_stb   <= 1'b0;
            r_state <= S_WAIT;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cyc   <= 1'b0;
          r_stb   <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.req_ready_o  = (r_state == S_IDLE) && wb_rst_i;
  assign io_bus.resp_valid_o = r_resp_valid;
  assign io_bus.resp_dat_o   = r_resp_dat;
  assign io_bus.resp_err_o   = r_resp_err;
  assign io_bus.wb_cyc_o     = r_cyc;
  assign io_bus.wb_stb_o     = r_stb;
  assign io_bus.wb_we_o      = r_we;
  assign io_bus.wb_adr_o     = r_adr;
  assign io_bus.wb_dat_o     = r_dat;
  assign io_bus.wb_sel_o     = r_sel;

endmodule
